// File: rtl/reg8_share_ctrl.sv
// Round-robin sequencer that shares one 8-bit capture register between NREQ requesters.
// A granted byte is loaded, announced with a one-cycle dout_vld, and held for HOLD_CYC cycles.
module reg8_share_ctrl #(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned HOLD_CYC = 2,
  parameter int unsigned SRC_W    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [8*NREQ-1:0]     din,
  output logic [NREQ-1:0]       gnt,
  output logic [7:0]            dout,
  output logic                  dout_vld,
  output logic [SRC_W-1:0]      dout_src,
  output logic                  busy
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYC - 1);
  localparam logic [SRC_W-1:0] LAST_RST = SRC_W'(NREQ - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_nxt;
  logic [SRC_W-1:0]    last;
  logic [SRC_W-1:0]    last_nxt;

  logic [NREQ-1:0]     gnt_nxt;
  logic [DATA_W-1:0]   dout_nxt;
  logic                dout_vld_nxt;
  logic [SRC_W-1:0]    dout_src_nxt;
  logic                busy_nxt;

  logic                win_found;
  logic [SRC_W-1:0]    win_idx;
  logic [DATA_W-1:0]   win_byte;
  logic [NREQ-1:0]     win_onehot;

  // Rotating-priority search starting just after the last winner.
  always_comb begin : p_win_search
    int unsigned idx;
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = 32'(last) + k;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end
      if (!win_found && req[SRC_W'(idx)]) begin
        win_found = 1'b1;
        win_idx   = SRC_W'(idx);
      end
    end
  end

  // Winner byte and one-hot grant vector, constant-indexed mux.
  always_comb begin : p_win_decode
    win_byte   = '0;
    win_onehot = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (win_idx == SRC_W'(i)) begin
        win_byte      = din[DATA_W*i +: DATA_W];
        win_onehot[i] = 1'b1;
      end
    end
  end

  always_comb begin : p_fsm_next
    state_nxt    = state;
    cnt_nxt      = cnt;
    last_nxt     = last;
    gnt_nxt      = '0;
    dout_nxt     = dout;
    dout_vld_nxt = 1'b0;
    dout_src_nxt = dout_src;
    busy_nxt     = busy;

    case (state)
      ST_IDLE: begin
        busy_nxt = 1'b0;
        if (win_found) begin
          state_nxt    = ST_HOLD;
          cnt_nxt      = CNT_LOAD;
          last_nxt     = win_idx;
          gnt_nxt      = win_onehot;
          dout_nxt     = win_byte;
          dout_vld_nxt = 1'b1;
          dout_src_nxt = win_idx;
          busy_nxt     = 1'b1;
        end
      end
      ST_HOLD: begin
        // Requests are deliberately ignored until the hold window closes.
        if (cnt != '0) begin
          cnt_nxt = cnt - CNT_W'(1);
        end else begin
          state_nxt = ST_IDLE;
          busy_nxt  = 1'b0;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin : p_state_reg
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      last     <= LAST_RST;
      gnt      <= '0;
      dout     <= '0;
      dout_vld <= 1'b0;
      dout_src <= '0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      last     <= last_nxt;
      gnt      <= gnt_nxt;
      dout     <= dout_nxt;
      dout_vld <= dout_vld_nxt;
      dout_src <= dout_src_nxt;
      busy     <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_reg8_share_ctrl.sv
// Bench for reg8_share_ctrl: cycle-level model based on load spacing and rotating priority,
// plus directed scenarios with hand-computed expectations.
module tb_reg8_share_ctrl;

  localparam int unsigned NREQ     = 4;
  localparam int unsigned HOLD_CYC = 2;
  localparam int unsigned SRC_W    = 2;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NREQ-1:0]      req;
  logic [8*NREQ-1:0]    din;
  logic [NREQ-1:0]      gnt;
  logic [7:0]           dout;
  logic                 dout_vld;
  logic [SRC_W-1:0]     dout_src;
  logic                 busy;

  always #5 clk = ~clk;

  reg8_share_ctrl #(.NREQ(NREQ), .HOLD_CYC(HOLD_CYC), .SRC_W(SRC_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .din      (din),
    .gnt      (gnt),
    .dout     (dout),
    .dout_vld (dout_vld),
    .dout_src (dout_src),
    .busy     (busy)
  );

  int n_checks = 0;
  int n_fails  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a load may happen once HOLD_CYC+1 edges have passed since the previous one.
  bit              m_on = 1'b0;
  int              m_since;
  int              m_k;
  int              m_i;
  int              m_last;
  int              m_src;
  bit              m_found;
  logic [7:0]      m_dout;
  logic [NREQ-1:0] m_gnt;
  bit              m_vld;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_on    = 1'b1;
      m_since = HOLD_CYC;
      m_last  = NREQ - 1;
      m_dout  = 8'h00;
      m_src   = 0;
      m_gnt   = '0;
      m_vld   = 1'b0;
    end else if (m_on) begin
      m_k     = (m_since < 1000) ? m_since + 1 : m_since;
      m_gnt   = '0;
      m_vld   = 1'b0;
      m_found = 1'b0;
      if (m_k >= HOLD_CYC + 1 && req != '0) begin
        for (int s = 1; s <= NREQ; s++) begin
          m_i = (m_last + s) % NREQ;
          if (!m_found && req[m_i]) begin
            m_found    = 1'b1;
            m_last     = m_i;
            m_src      = m_i;
            m_dout     = din[8*m_i +: 8];
            m_gnt[m_i] = 1'b1;
            m_vld      = 1'b1;
          end
        end
      end
      m_since = m_found ? 0 : m_k;
    end
    #1;
    if (m_on) begin
      chk("model_gnt",  32'(gnt),      32'(m_gnt));
      chk("model_dout", 32'(dout),     32'(m_dout));
      chk("model_vld",  32'(dout_vld), 32'(m_vld));
      chk("model_src",  32'(dout_src), m_src);
      chk("model_busy", 32'(busy),     32'(m_since < HOLD_CYC));
    end
  end

  task automatic wait_busy_low(input int budget, input string tag);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    chk(tag, 32'(ok), 32'h1);
  endtask

  task automatic wait_vld(input int budget, input string tag);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (dout_vld) begin
        ok = 1'b1;
        break;
      end
    end
    chk(tag, 32'(ok), 32'h1);
  endtask

  logic [7:0] exp_seq [5];
  logic [7:0] got_seq [5];
  int         got_cyc [5];
  int         n_got;
  int         cyc;

  initial begin
    rst_n = 1'b0;
    req   = '0;
    din   = '0;
    exp_seq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};

    // Reset and idle hold
    repeat (2) @(negedge clk);
    chk("rst_gnt",  32'(gnt),  32'h0);
    chk("rst_dout", 32'(dout), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_vld",  32'(dout_vld), 32'h0);
    chk("idle_dout", 32'(dout),     32'h0);

    // Single requester 2
    req          = 4'b0100;
    din[23:16]   = 8'hA5;
    @(negedge clk);
    chk("single_gnt",  32'(gnt),      32'h4);
    chk("single_dout", 32'(dout),     32'hA5);
    chk("single_vld",  32'(dout_vld), 32'h1);
    chk("single_src",  32'(dout_src), 32'h2);
    chk("single_busy", 32'(busy),     32'h1);
    req = '0;
    @(negedge clk);
    chk("single_busy2", 32'(busy), 32'h1);
    chk("single_gnt2",  32'(gnt),  32'h0);
    @(negedge clk);
    chk("single_idle", 32'(busy), 32'h0);

    // All four requesting, from a fresh pointer
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    din   = {8'h44, 8'h33, 8'h22, 8'h11};
    req   = 4'b1111;
    n_got = 0;
    cyc   = 0;
    while (n_got < 5 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (dout_vld) begin
        got_seq[n_got] = dout;
        got_cyc[n_got] = cyc;
        n_got++;
      end
    end
    req = '0;
    chk("rr_count", 32'(n_got), 32'h5);
    for (int j = 0; j < n_got; j++) begin
      chk("rr_byte", 32'(got_seq[j]), 32'(exp_seq[j]));
      if (j > 0) chk("rr_spacing", 32'(got_cyc[j] - got_cyc[j-1]), 32'(HOLD_CYC + 1));
    end
    wait_busy_low(10, "rr_busy_timeout");

    // Requester 1 granted, then 0 beats 1 on the next round
    din[15:8] = 8'h77;
    req       = 4'b0010;
    wait_vld(10, "ptr_vld_timeout");
    chk("ptr_src1", 32'(dout_src), 32'h1);
    chk("ptr_gnt1", 32'(gnt),      32'h2);
    req = '0;
    wait_busy_low(10, "ptr_busy_timeout");
    req = 4'b0011;
    @(negedge clk);
    chk("ptr_gnt0", 32'(gnt),      32'h1);
    chk("ptr_src0", 32'(dout_src), 32'h0);
    chk("ptr_dout", 32'(dout),     32'h11);
    req = '0;
    wait_busy_low(10, "ptr_busy_timeout2");

    // Reset during HOLD with requester 3 held
    din[31:24] = 8'h5A;
    req        = 4'b1000;
    @(negedge clk);
    chk("hrst_load", 32'(dout), 32'h5A);
    chk("hrst_busy", 32'(busy), 32'h1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("hrst_dout", 32'(dout), 32'h0);
    chk("hrst_bsy0", 32'(busy), 32'h0);
    chk("hrst_gnt0", 32'(gnt),  32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("hrst_gnt3", 32'(gnt),      32'h8);
    chk("hrst_src3", 32'(dout_src), 32'h3);
    chk("hrst_reld", 32'(dout),     32'h5A);

    // Requester 2 pulses only inside HOLD: must be ignored
    din[23:16] = 8'hC3;
    req        = 4'b0100;
    @(negedge clk);
    req = '0;
    chk("pulse_busy", 32'(busy), 32'h1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("pulse_gnt", 32'(gnt), 32'h0);
    end
    chk("pulse_dout", 32'(dout), 32'h5A);
    chk("pulse_src",  32'(dout_src), 32'h3);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
